lfsr_stream_checker: RTL and testbench
======================================

// Module: lfsr_stream_checker
// PURPOSE
//  Self-synchronising checker for the 12-bit pseudo-random word stream made by our 24-bit LFSR
//  (x^24+x^23+x^22+x^17, shift-left, new bit = s[23]^s[22]^s[21]^s[16] into bit 0).
//  Rebuilds the 24-bit generator state from the overlapping output words, then predicts and checks every word.
//  Sits on the consumer side of the random-number path (pattern/noise fill, BIST of the VGA pipeline).
//  Reports lock status, per-word error pulses and a saturating error count.
// PARAMETERS
//  ERR_THRESH  4   consecutive mismatching words in TRACK that drop lock (>=1)
//  CNT_W       16  width of err_count
// PORTS
//  clk        in   1      clock
//  reset_n    in   1      synchronous, active-low reset
//  in_valid   in   1      in_word holds one generator word this cycle
//  in_word    in   12     generator word (generator state bits [11:0])
//  clear      in   1      synchronous clear of err_count
//  locked     out  1      1 = state reconstructed, stream being checked
//  err_pulse  out  1      1-cycle pulse per mismatching word while locked
//  err_count  out  CNT_W  saturating count of mismatching words
//  exp_word   out  12     word the checker expects next (debug; valid when locked)
// BEHAVIOUR
//  Reset: state=ACQUIRE, H(24b history)=0, acq_cnt=0, consec_err=0, locked=0, err_pulse=0,
//   err_count=0, exp_word=0. Reset mid-operation aborts any acquisition or tracking immediately.
//  Cycles with in_valid=0 change nothing: no shift, no check, err_pulse=0.
//  Prediction: fb = H[23]^H[22]^H[21]^H[16]; next H = {H[22:0],fb}; expected word = next H[11:0].
//  ACQUIRE:
//   - acq_cnt==0: H<={12'b0,in_word}; acq_cnt<=1.
//   - acq_cnt>=1: overlap check in_word[11:1]==H[10:0].
//     Match: H<={H[22:0],in_word[0]}; acq_cnt++.
//     Mismatch: restart with this word as first word (H<={12'b0,in_word}; acq_cnt<=1).
//   - The match that makes acq_cnt==13 fills all 24 bits of H.
//     If the new H==0 (degenerate all-zero stream): acq_cnt<=0 and stay in ACQUIRE.
//     Otherwise go to TRACK, with locked=1 from the next cycle.
//   - Mismatches during ACQUIRE never pulse err_pulse or count.
//  TRACK (per valid word):
//   - Compare in_word with the expected word; H always advances to next H (free-running predictor,
//     input never loaded), so one corrupted word yields exactly one error.
//   - Match: consec_err<=0.
//   - Mismatch: err_pulse=1 next cycle; err_count+1, saturating at 2^CNT_W-1; consec_err++.
//   - consec_err reaching ERR_THRESH: -> ACQUIRE with acq_cnt=0, locked=0 next cycle.
//     That word's error is still counted and pulsed.
//  clear: err_count<=0. clear has priority over a same-cycle increment (result 0).
//  All outputs registered. exp_word updates whenever H advances. Latency word->err_pulse: 1 cycle.
// TESTING
//  1 Drive from rand_generator (seed 0x123456) with in_valid from its first post-reset word.
//    Words 0x456,0x8AC,... -> locked=1 the cycle after the 13th word.
//    Then 10000 words give err_count=0 and exp_word==in_word every valid cycle.
//  2 Locked; flip bit 0 of one word -> one err_pulse, err_count=1, locked stays 1,
//    no further errors.
//  3 Locked; invert 4 consecutive words (ERR_THRESH=4) -> 4 pulses, err_count=4,
//    locked=0 after the 4th; relock 13 clean words later.
//  4 Stream of 0x000 for 50 valid words -> locked never 1, err_count=0.
//  5 Acquisition: replace word 5 with 0xA5A -> restart, lock after 13 consistent words
//    counted from 0xA5A's successor chain (or later); in_valid gaps of 3 cycles do not break lock.
//  6 CNT_W=4, locked, 20 isolated errors -> err_count=15.
//    clear coincident with an error -> err_count=0.
//    reset_n low mid-TRACK -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising checker for the 12-bit word stream
// of the 24-bit LFSR x^24+x^23+x^22+x^17 (shift-left, feedback into bit 0).
// ACQUIRE rebuilds the generator state from 13 overlapping words; TRACK runs a
// free-running predictor and flags every word that disagrees with it.
module lfsr_stream_checker #(
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [11:0]      in_word,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [11:0]      exp_word
);

    localparam int CE_W = (ERR_THRESH < 2) ? 1 : $clog2(ERR_THRESH);

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_t;

    state_t            state;
    logic [23:0]       hist;
    logic [3:0]        acq_cnt;
    logic [CE_W-1:0]   consec_err;

    logic [23:0]       h_next;
    logic [23:0]       h_acq;
    logic [23:0]       h_acq_next;
    logic [23:0]       h_next_next;
    logic [23:0]       h_load_next;
    logic              overlap_ok;
    logic              word_ok;
    logic              cnt_sat;
    logic              consec_hit;

    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    endfunction

    // Candidate next histories and the checks that choose between them.
    always_comb begin
        h_next      = lfsr_next(hist);
        h_acq       = {hist[22:0], in_word[0]};
        h_acq_next  = lfsr_next(h_acq);
        h_next_next = lfsr_next(h_next);
        h_load_next = lfsr_next({12'b0, in_word});
        // Consecutive words share 11 bits: new word's top 11 = previous word's low 11.
        overlap_ok  = (in_word[11:1] == hist[10:0]);
        word_ok     = (in_word == h_next[11:0]);
        cnt_sat     = &err_count;
        // consec_err never exceeds ERR_THRESH-1, so equality marks the threshold.
        consec_hit  = (consec_err == CE_W'(ERR_THRESH - 1));
    end

    // Acquire/track state machine with registered outputs and error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ACQUIRE;
            hist       <= '0;
            acq_cnt    <= '0;
            consec_err <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            exp_word   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clear)
                err_count <= '0;

            if (in_valid) begin
                case (state)
                    ACQUIRE: begin
                        if (acq_cnt == 4'd0 || !overlap_ok) begin
                            // Start (or restart) with this word as the first one.
                            hist     <= {12'b0, in_word};
                            exp_word <= h_load_next[11:0];
                            acq_cnt  <= 4'd1;
                        end else begin
                            hist     <= h_acq;
                            exp_word <= h_acq_next[11:0];
                            if (acq_cnt == 4'd12) begin
                                // History now holds all 24 bits; an all-zero
                                // state can never come from a running LFSR.
                                if (h_acq == 24'b0) begin
                                    acq_cnt <= 4'd0;
                                end else begin
                                    acq_cnt    <= 4'd0;
                                    consec_err <= '0;
                                    state      <= TRACK;
                                    locked     <= 1'b1;
                                end
                            end else begin
                                acq_cnt <= acq_cnt + 4'd1;
                            end
                        end
                    end
                    TRACK: begin
                        // Predictor free-runs: the input is never loaded, so a
                        // single corrupted word costs exactly one error.
                        hist     <= h_next;
                        exp_word <= h_next_next[11:0];
                        if (word_ok) begin
                            consec_err <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (!clear && !cnt_sat)
                                err_count <= err_count + CNT_W'(1);
                            if (consec_hit) begin
                                consec_err <= '0;
                                acq_cnt    <= 4'd0;
                                state      <= ACQUIRE;
                                locked     <= 1'b0;
                            end else begin
                                consec_err <= consec_err + CE_W'(1);
                            end
                        end
                    end
                    default: state <= ACQUIRE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: a 16-bit-counter instance and a
// 4-bit-counter instance share every input.
module tb_lfsr_stream_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] in_word = '0;

    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [11:0] exp_word;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;
    logic [11:0] exp_word4;

    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    logic [23:0] gen;
    logic [11:0] w;

    lfsr_stream_checker #(.ERR_THRESH(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_word(in_word),
        .clear(clear), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .exp_word(exp_word)
    );

    lfsr_stream_checker #(.ERR_THRESH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_word(in_word),
        .clear(clear), .locked(locked4), .err_pulse(err_pulse4),
        .err_count(err_count4), .exp_word(exp_word4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle at a falling edge; outputs are valid at the next one.
    task automatic step(input logic v, input logic [11:0] wd, input logic c);
        in_valid = v;
        in_word  = wd;
        clear    = c;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // Reference generator: emit low 12 bits, then advance.
    task automatic next_word(output logic [11:0] wd);
        wd  = gen[11:0];
        gen = {gen[22:0], gen[23] ^ gen[22] ^ gen[21] ^ gen[16]};
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        chk("rst_locked",   locked,    1'b0);
        chk("rst_pulse",    err_pulse, 1'b0);
        chk("rst_count",    err_count, 16'h0);
        chk("rst_exp",      exp_word,  12'h000);
        chk("rst_locked4",  locked4,   1'b0);
        reset_n = 1'b1;

        // 1: clean stream from seed 0x123456 locks after 13 words and stays clean.
        gen = 24'h123456;
        next_word(w); step(1'b1, 12'h456, 1'b0);
        next_word(w); step(1'b1, 12'h8AC, 1'b0);
        for (int i = 2; i < 12; i++) begin
            next_word(w); step(1'b1, w, 1'b0);
        end
        chk("t1_unlocked_12", locked, 1'b0);
        next_word(w); step(1'b1, w, 1'b0);
        chk("t1_locked_13", locked, 1'b1);
        chk("t1_exp_first", exp_word, gen[11:0]);
        for (int i = 0; i < 10000; i++) begin
            next_word(w);
            chk("t1_exp_track", exp_word, w);
            step(1'b1, w, 1'b0);
        end
        chk("t1_count", err_count, 16'h0);
        chk("t1_locked_end", locked, 1'b1);

        // 2: single bit flip -> exactly one error.
        next_word(w); step(1'b1, w ^ 12'h001, 1'b0);
        chk("t2_pulse", err_pulse, 1'b1);
        chk("t2_count", err_count, 16'h1);
        chk("t2_locked", locked, 1'b1);
        next_word(w); step(1'b1, w, 1'b0);
        chk("t2_pulse_off", err_pulse, 1'b0);
        for (int i = 0; i < 20; i++) begin
            next_word(w); step(1'b1, w, 1'b0);
        end
        chk("t2_count_hold", err_count, 16'h1);
        chk("t2_locked_hold", locked, 1'b1);

        // 3: four inverted words drop lock; 13 clean words relock.
        step(1'b0, 12'h000, 1'b1);
        chk("t3_cleared", err_count, 16'h0);
        for (int k = 0; k < 4; k++) begin
            next_word(w); step(1'b1, ~w, 1'b0);
            chk("t3_pulse", err_pulse, 1'b1);
            chk("t3_locked", locked, (k < 3) ? 1'b1 : 1'b0);
            chk("t3_count", err_count, 32'(k + 1));
        end
        chk("t3_count4", err_count4, 4'h4);
        for (int i = 0; i < 12; i++) begin
            next_word(w); step(1'b1, w, 1'b0);
        end
        chk("t3_unlocked_12", locked, 1'b0);
        chk("t3_count_acq", err_count, 16'h4);
        next_word(w); step(1'b1, w, 1'b0);
        chk("t3_relocked", locked, 1'b1);
        chk("t3_exp_relock", exp_word, gen[11:0]);

        // 4: all-zero stream never locks.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 12'h000, 1'b0);
            chk("t4_locked", locked, 1'b0);
        end
        chk("t4_count", err_count, 16'h0);

        // 5: word 5 replaced by 0xA5A; word 6 restarts, lock after word 18; gaps harmless.
        do_reset();
        gen = 24'h123456;
        for (int i = 0; i < 19; i++) begin
            next_word(w);
            if (i == 5) w = 12'hA5A;
            step(1'b1, w, 1'b0);
            if (i == 10) begin
                step(1'b0, 12'hFFF, 1'b0);
                step(1'b0, 12'hFFF, 1'b0);
                step(1'b0, 12'hFFF, 1'b0);
            end
            if (i == 17) chk("t5_unlocked_17", locked, 1'b0);
        end
        chk("t5_locked_18", locked, 1'b1);
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            chk("t5_exp_gap", exp_word, w);
            step(1'b1, w, 1'b0);
            step(1'b0, ~w, 1'b0);
            step(1'b0, ~w, 1'b0);
            step(1'b0, ~w, 1'b0);
            chk("t5_gap_pulse", err_pulse, 1'b0);
        end
        chk("t5_locked_end", locked, 1'b1);
        chk("t5_count", err_count, 16'h0);

        // 6: saturation, clear priority, reset mid-TRACK.
        do_reset();
        gen = 24'h00C0DE;
        for (int i = 0; i < 13; i++) begin
            next_word(w); step(1'b1, w, 1'b0);
        end
        chk("t6_locked", locked, 1'b1);
        for (int i = 0; i < 20; i++) begin
            next_word(w); step(1'b1, w ^ 12'h001, 1'b0);
            next_word(w); step(1'b1, w, 1'b0);
        end
        chk("t6_count16", err_count, 16'd20);
        chk("t6_count4_sat", err_count4, 4'hF);
        chk("t6_locked_iso", locked, 1'b1);
        next_word(w); step(1'b1, w ^ 12'h001, 1'b1);
        chk("t6_clear16", err_count, 16'h0);
        chk("t6_clear4", err_count4, 4'h0);
        chk("t6_clear_pulse", err_pulse, 1'b1);
        next_word(w);
        reset_n = 1'b0;
        step(1'b1, w ^ 12'h001, 1'b0);
        chk("t6_rst_locked", locked, 1'b0);
        chk("t6_rst_pulse", err_pulse, 1'b0);
        chk("t6_rst_count", err_count, 16'h0);
        chk("t6_rst_exp", exp_word, 12'h000);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
